// File: rtl/mmio_port_pkg.sv
// Shared constants for the MMIO port responder: register offsets
// (word index = Address[4:2]), STATUS bit positions and DIV width.
package mmio_port_pkg;

    localparam logic [2:0] OFF_OUT    = 3'd0;
    localparam logic [2:0] OFF_IN     = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_PUSH   = 3'd3;
    localparam logic [2:0] OFF_DIV    = 3'd4;
    localparam logic [2:0] OFF_CTRL   = 3'd5;

    localparam int ST_IN_CHANGED = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_EMPTY      = 2;
    localparam int ST_OVERFLOW   = 3;
    localparam int ST_COUNT      = 4;   // count occupies bits [7:4]

    localparam int DIV_W = 16;

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous FIFO, power-of-2 depth, no bypass. A push while full is
// accepted only when a pop happens in the same cycle.
module mmio_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    // Storage array; contents are don't-care while the entry is not counted
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    // Pointers wrap naturally at the power-of-2 depth; count tracks occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped port responder: OUT register, synchronized PortIn with
// change flag, paced output FIFO draining into PortOut.
// Optional interrupt support (CTRL register, irq output) is compiled in
// when MMIO_IRQ_EN is defined; otherwise offset 5 reads 0 and irq is 0.
module mmio_port_responder
    import mmio_port_pkg::*;
#(
    parameter logic [31:0]      BASE_ADDR  = 32'hFFFF_0000,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [DIV_W-1:0] DIV_RESET  = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic [31:0] PortOut,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]       off;
    logic             wr, rd;
    logic             wr_out, wr_status, wr_push, wr_div, rd_in;
    logic [7:0]       sync1, in_sync, in_prev;
    logic             in_changed, overflow;
    logic [DIV_W-1:0] div_q, drain_cnt;
    logic             pop;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [31:0]      fifo_head;
    logic [31:0]      cnt_ext;
    logic [31:0]      status;
    logic [31:0]      read_data;

    assign Hit       = (Address[31:5] == BASE_ADDR[31:5]);
    assign off       = Address[4:2];
    assign wr        = Hit && MemWrite;
    assign rd        = Hit && MemRead;
    assign wr_out    = wr && (off == OFF_OUT);
    assign wr_status = wr && (off == OFF_STATUS);
    assign wr_push   = wr && (off == OFF_PUSH);
    assign wr_div    = wr && (off == OFF_DIV);
    assign rd_in     = rd && (off == OFF_IN);

    // A CPU store to OUT_DATA owns PortOut this cycle; the pop waits a cycle
    assign pop = !fifo_empty && (drain_cnt == '0) && !wr_out;

    mmio_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_push),
        .pop   (pop),
        .din   (WriteData),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Two-flop synchronizer plus previous sample for change detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1   <= '0;
            in_sync <= '0;
            in_prev <= '0;
        end else begin
            sync1   <= PortIn;
            in_sync <= sync1;
            in_prev <= in_sync;
        end
    end

    // Sticky flags: change detection beats a read-clear; overflow is W1C
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_changed <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (in_sync != in_prev) in_changed <= 1'b1;
            else if (rd_in)         in_changed <= 1'b0;
            // a push while full is only dropped when no pop frees a slot
            if (wr_push && fifo_full && !pop)      overflow <= 1'b1;
            else if (wr_status && WriteData[ST_OVERFLOW]) overflow <= 1'b0;
        end
    end

    // PortOut, DIV and the drain pacing counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            PortOut   <= '0;
            div_q     <= DIV_RESET;
            drain_cnt <= '0;
        end else begin
            if (wr_out)   PortOut <= WriteData;
            else if (pop) PortOut <= fifo_head;
            if (wr_div) div_q <= WriteData[DIV_W-1:0];
            // empty FIFO parks the counter at 0 so a new entry pops next cycle
            if (fifo_empty)             drain_cnt <= '0;
            else if (drain_cnt == '0) begin
                if (pop) drain_cnt <= div_q;
            end else                    drain_cnt <= drain_cnt - DIV_W'(1);
        end
    end

`ifdef MMIO_IRQ_EN
    logic ie, irq_q;

    // Interrupt enable register and registered interrupt output
    always_ff @(posedge clk) begin
        if (!reset) begin
            ie    <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wr && (off == OFF_CTRL)) ie <= WriteData[0];
            irq_q <= ie && (in_changed || overflow);
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign cnt_ext = 32'(fifo_count);

    // Combinational read mux so a single-cycle core completes loads in one cycle
    always_comb begin
        status = '0;
        status[ST_IN_CHANGED]   = in_changed;
        status[ST_FULL]         = fifo_full;
        status[ST_EMPTY]        = fifo_empty;
        status[ST_OVERFLOW]     = overflow;
        status[ST_COUNT +: 4]   = cnt_ext[3:0];
        read_data = '0;
        if (rd) begin
            case (off)
                OFF_OUT:    read_data = PortOut;
                OFF_IN:     read_data = {24'b0, in_sync};
                OFF_STATUS: read_data = status;
                OFF_DIV:    read_data = {{(32-DIV_W){1'b0}}, div_q};
`ifdef MMIO_IRQ_EN
                OFF_CTRL:   read_data = {31'b0, ie};
`endif
                default:    read_data = '0;
            endcase
        end
    end
    assign ReadData = read_data;

    logic unused_bits;
    assign unused_bits = ^{Address[1:0], cnt_ext[31:4]};

endmodule

// File: tb/tb_mmio_port_responder.sv
// Randomized + directed bench for mmio_port_responder against a queue-based
// behavioural model of the register map, FIFO pacing and input change flag.
module tb_mmio_port_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address, WriteData;
    logic        MemWrite, MemRead;
    logic [7:0]  PortIn;
    logic [31:0] ReadData, PortOut;
    logic        Hit, irq;

    always #5 clk = ~clk;

    mmio_port_responder dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn),
        .ReadData(ReadData), .Hit(Hit), .PortOut(PortOut), .irq(irq)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] last_rd;

    // ---------------- behavioural model ----------------
    logic [31:0] m_q[$];
    int          m_cnt;
    logic [31:0] m_out;
    logic [15:0] m_div;
    logic [7:0]  m_s1, m_s2, m_prev;
    bit          m_chg, m_ovf, m_ie, m_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hit();
        return Address[31:5] == 27'h7FF_F800;
    endfunction

    function automatic logic [31:0] m_read();
        logic [31:0] r;
        int n;
        r = 32'h0;
        n = m_q.size();
        if (m_hit() && MemRead) begin
            case (Address[4:2])
                3'd0: r = m_out;
                3'd1: r = {24'b0, m_s2};
                3'd2: r = {24'b0, 4'(n), m_ovf, (n == 0), (n == 4), m_chg};
                3'd4: r = {16'b0, m_div};
`ifdef MMIO_IRQ_EN
                3'd5: r = {31'b0, m_ie};
`endif
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_cnt = 0; m_out = 0; m_div = 0;
        m_s1 = 0; m_s2 = 0; m_prev = 0;
        m_chg = 0; m_ovf = 0; m_ie = 0; m_irq = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic m_step();
        logic [2:0]  off;
        bit          wr, rd, was_full, was_empty, pop, n_chg, n_irq;
        int          n_cnt;
        logic [31:0] head;
        off       = Address[4:2];
        wr        = m_hit() && MemWrite;
        rd        = m_hit() && MemRead;
        was_full  = (m_q.size() == 4);
        was_empty = (m_q.size() == 0);
        pop       = !was_empty && m_cnt == 0 && !(wr && off == 3'd0);
        head      = was_empty ? 32'h0 : m_q[0];
        n_cnt     = was_empty ? 0 : (m_cnt == 0 ? (pop ? int'(m_div) : 0) : m_cnt - 1);
        n_irq     = m_ie && (m_chg || m_ovf);
        n_chg     = (m_s2 != m_prev) ? 1'b1 : ((rd && off == 3'd1) ? 1'b0 : m_chg);

        if (wr && off == 3'd0) m_out = WriteData;
        else if (pop)          m_out = head;
        if (pop) void'(m_q.pop_front());
        if (wr && off == 3'd3) begin
            if (!was_full || pop) m_q.push_back(WriteData);
            else                  m_ovf = 1'b1;
        end
        if (wr && off == 3'd2 && WriteData[3]) m_ovf = 1'b0;
        if (wr && off == 3'd4) m_div = WriteData[15:0];
`ifdef MMIO_IRQ_EN
        if (wr && off == 3'd5) m_ie = WriteData[0];
        m_irq = n_irq;
`else
        m_irq = 1'b0;
        if (n_irq) m_irq = 1'b0;
`endif
        m_cnt  = n_cnt;
        m_chg  = n_chg;
        m_prev = m_s2;
        m_s2   = m_s1;
        m_s1   = PortIn;
    endtask

    // One bus cycle: drive, compare every output against the model, advance model
    task automatic tick(input logic rst_n, input logic [31:0] a, input logic [31:0] wd,
                        input bit we, input bit re, input logic [7:0] pin);
        @(negedge clk);
        reset = rst_n; Address = a; WriteData = wd;
        MemWrite = we; MemRead = re; PortIn = pin;
        #1;
        check("ReadData", ReadData, m_read());
        check("Hit", {31'b0, Hit}, {31'b0, m_hit()});
        check("PortOut", PortOut, m_out);
        check("irq", {31'b0, irq}, {31'b0, m_irq});
        last_rd = ReadData;
        if (!rst_n) m_reset();
        else        m_step();
    endtask

    function automatic logic [31:0] ra(input int off);
        return 32'hFFFF_0000 | (32'(off) << 2);
    endfunction

    initial begin
        reset = 1'b0; Address = 0; WriteData = 0; MemWrite = 0; MemRead = 0; PortIn = 0;
        repeat (2) @(posedge clk);
        m_reset();

        // reset state
        tick(1, ra(2), 0, 0, 1, 8'h00); check("rst_status", last_rd, 32'h4);
        tick(1, ra(0), 0, 0, 1, 8'h00); check("rst_out_read", last_rd, 32'h0);
        check("rst_portout", PortOut, 32'h0);

        // OUT_DATA store / read, and a non-hit store
        tick(1, ra(0), 32'hA5A5_0001, 1, 0, 8'h00);
        tick(1, ra(0), 0, 0, 1, 8'h00);
        check("out_read", last_rd, 32'hA5A5_0001);
        check("out_portout", PortOut, 32'hA5A5_0001);
        tick(1, 32'hFFFF_0100, 32'h1234_5678, 1, 0, 8'h00);
        check("miss_hit", {31'b0, Hit}, 32'h0);
        tick(1, 32'h0, 0, 0, 0, 8'h00);
        check("miss_portout", PortOut, 32'hA5A5_0001);

        // PortIn change: visible after 2 edges, flag one edge later
        tick(1, 32'h0, 0, 0, 0, 8'h3C);
        tick(1, 32'h0, 0, 0, 0, 8'h3C);
        tick(1, ra(1), 0, 0, 1, 8'h3C); check("in_data", last_rd, 32'h3C);
        tick(1, ra(2), 0, 0, 1, 8'h3C); check("in_chg_set", {31'b0, last_rd[0]}, 32'h1);
        tick(1, ra(1), 0, 0, 1, 8'h3C);
        tick(1, ra(2), 0, 0, 1, 8'h3C); check("in_chg_clr", {31'b0, last_rd[0]}, 32'h0);

        // DIV=3 pacing: pops land at +1, +5, +9 edges after the first push
        tick(1, ra(4), 32'd3, 1, 0, 8'h3C);
        tick(1, ra(3), 32'd1, 1, 0, 8'h3C);
        tick(1, ra(3), 32'd2, 1, 0, 8'h3C);
        tick(1, ra(3), 32'd3, 1, 0, 8'h3C);
        check("pace_first", PortOut, 32'd1);
        for (int k = 3; k <= 10; k++) begin
            tick(1, 32'h0, 0, 0, 0, 8'h3C);
            if (k == 5)  check("pace_hold1", PortOut, 32'd1);
            if (k == 6)  check("pace_second", PortOut, 32'd2);
            if (k == 9)  check("pace_hold2", PortOut, 32'd2);
            if (k == 10) check("pace_third", PortOut, 32'd3);
        end
        tick(1, ra(2), 0, 0, 1, 8'h3C); check("drain_empty", {31'b0, last_rd[2]}, 32'h1);

        // Overflow: first word drains at once, next four fill, sixth is dropped
        tick(1, ra(4), 32'hFFFF, 1, 0, 8'h3C);
        for (int i = 0; i < 6; i++) tick(1, ra(3), 32'd10 + 32'(i), 1, 0, 8'h3C);
        tick(1, ra(2), 0, 0, 1, 8'h3C); check("ovf_status", last_rd, 32'h4A);
        check("ovf_portout", PortOut, 32'd10);
        tick(1, ra(2), 32'h08, 1, 0, 8'h3C);
        tick(1, ra(2), 0, 0, 1, 8'h3C); check("ovf_clear", last_rd, 32'h42);

        // Reset with queued entries
        tick(0, 32'h0, 0, 0, 0, 8'h3C);
        tick(1, ra(2), 0, 0, 1, 8'h3C); check("rst_mid_status", last_rd, 32'h4);
        check("rst_mid_portout", PortOut, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] a, wd;
            logic [7:0]  pin;
            bit          we, re, rn;
            if ($urandom_range(0, 9) != 0) a = ra($urandom_range(0, 7)) | 32'($urandom_range(0, 3));
            else                           a = $urandom;
            wd  = (a[4:2] == 3'd4) ? 32'($urandom_range(0, 4)) : $urandom;
            we  = ($urandom_range(0, 9) < 4);
            re  = ($urandom_range(0, 9) < 4);
            pin = ($urandom_range(0, 7) == 0) ? 8'($urandom) : PortIn;
            rn  = ($urandom_range(0, 499) != 0);
            tick(rn, a, wd, we, re, pin);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
